// File: rtl/id_ex_pipe_reg_pkg.sv
// Shared RV32 decode constants for the ID/EX stage: opcodes, control-bundle bit positions
// and operand-use helpers.
package id_ex_pipe_reg_pkg;

  localparam int CTRL_W = 12;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_REG   = 7'b0110011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_BRANCH= 7'b1100011;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  // Control bundle layout: {RegWrite,ALUSrc,ALUSrc_pc,MemWrite,MemRead,ResultSrc,Branch,Jump,ALUOp,0}
  localparam int CTRL_REGWRITE  = 11;
  localparam int CTRL_ALUSRC    = 10;
  localparam int CTRL_ALUSRC_PC = 9;
  localparam int CTRL_MEMWRITE  = 8;
  localparam int CTRL_MEMREAD   = 7;
  localparam int CTRL_RES_HI    = 6;
  localparam int CTRL_RES_LO    = 5;
  localparam int CTRL_BRANCH    = 4;
  localparam int CTRL_JUMP      = 3;
  localparam int CTRL_ALUOP_HI  = 2;
  localparam int CTRL_ALUOP_LO  = 1;

  typedef enum logic [1:0] {
    RES_ALU = 2'b00,
    RES_MEM = 2'b01,
    RES_PC4 = 2'b10
  } result_src_e;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } alu_op_e;

  function automatic logic uses_rs1(input logic [6:0] op);
    logic use_s;
    case (op)
      OP_LUI, OP_AUIPC, OP_JAL: use_s = 1'b0;
      default:                  use_s = 1'b1;
    endcase
    return use_s;
  endfunction

  function automatic logic uses_rs2(input logic [6:0] op);
    logic use_s;
    case (op)
      OP_REG, OP_STORE, OP_BRANCH: use_s = 1'b1;
      default:                     use_s = 1'b0;
    endcase
    return use_s;
  endfunction

endpackage

// File: rtl/id_ex_pipe_reg_load_use_detect.sv
// Combinational load-use detector: flags an ID instruction that reads the destination of
// a load currently sitting in EX.
module id_ex_pipe_reg_load_use_detect
  import id_ex_pipe_reg_pkg::*;
(
  input  logic       id_valid_i,
  input  logic [6:0] id_op_i,
  input  logic [4:0] id_rs1_i,
  input  logic [4:0] id_rs2_i,
  input  logic       ex_valid_i,
  input  logic       ex_mem_read_i,
  input  logic [4:0] ex_rd_i,
  output logic       load_use_o
);

  logic rs1_hit_s;
  logic rs2_hit_s;
  logic ex_load_s;

  assign rs1_hit_s  = uses_rs1(id_op_i) & (id_rs1_i == ex_rd_i);
  assign rs2_hit_s  = uses_rs2(id_op_i) & (id_rs2_i == ex_rd_i);
  // x0 is never a real dependency, so a load into x0 can never stall
  assign ex_load_s  = ex_valid_i & ex_mem_read_i & (ex_rd_i != 5'd0);
  assign load_use_o = ex_load_s & id_valid_i & (rs1_hit_s | rs2_hit_s);

endmodule

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register with load-use stall, flush bubbles and saturating bubble counters.
// Priority per edge: reset, hold, flush, load-use, normal load.
module id_ex_pipe_reg
  import id_ex_pipe_reg_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              hold_i,
  input  logic              flush_i,
  input  logic              id_valid_i,
  input  logic [6:0]        id_op_i,
  input  logic [CTRL_W-1:0] id_ctrl_i,
  input  logic [XLEN-1:0]   id_pc_i,
  input  logic [XLEN-1:0]   id_pc4_i,
  input  logic [XLEN-1:0]   id_rs1_data_i,
  input  logic [XLEN-1:0]   id_rs2_data_i,
  input  logic [XLEN-1:0]   id_imm_i,
  input  logic [4:0]        id_rs1_i,
  input  logic [4:0]        id_rs2_i,
  input  logic [4:0]        id_rd_i,
  input  logic [2:0]        id_funct3_i,
  input  logic              id_funct7b5_i,
  output logic              stall_o,
  output logic              ex_valid_o,
  output logic [CTRL_W-1:0] ex_ctrl_o,
  output logic [XLEN-1:0]   ex_pc_o,
  output logic [XLEN-1:0]   ex_pc4_o,
  output logic [XLEN-1:0]   ex_rs1_data_o,
  output logic [XLEN-1:0]   ex_rs2_data_o,
  output logic [XLEN-1:0]   ex_imm_o,
  output logic [4:0]        ex_rs1_o,
  output logic [4:0]        ex_rs2_o,
  output logic [4:0]        ex_rd_o,
  output logic [2:0]        ex_funct3_o,
  output logic              ex_funct7b5_o,
  output logic [CNT_W-1:0]  stall_cnt_o,
  output logic [CNT_W-1:0]  flush_cnt_o
);

  logic              valid_q, valid_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [XLEN-1:0]   pc_q, pc_d, pc4_q, pc4_d, rs1_data_q, rs1_data_d;
  logic [XLEN-1:0]   rs2_data_q, rs2_data_d, imm_q, imm_d;
  logic [4:0]        rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
  logic [2:0]        funct3_q, funct3_d;
  logic              funct7b5_q, funct7b5_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
  logic              load_use_s, bubble_s, load_s;

  id_ex_pipe_reg_load_use_detect u_load_use_detect (
    .id_valid_i    (id_valid_i),
    .id_op_i       (id_op_i),
    .id_rs1_i      (id_rs1_i),
    .id_rs2_i      (id_rs2_i),
    .ex_valid_i    (valid_q),
    .ex_mem_read_i (ctrl_q[CTRL_MEMREAD]),
    .ex_rd_i       (rd_q),
    .load_use_o    (load_use_s)
  );

  // A held flush is deliberately ignored: the source keeps flush_i up until hold drops
  assign bubble_s = ~hold_i & (flush_i | load_use_s);
  assign load_s   = ~hold_i & ~flush_i & ~load_use_s;
  assign stall_o  = hold_i | (load_use_s & ~flush_i);

  always_comb begin
    valid_d     = valid_q;
    ctrl_d      = ctrl_q;
    pc_d        = pc_q;
    pc4_d       = pc4_q;
    rs1_data_d  = rs1_data_q;
    rs2_data_d  = rs2_data_q;
    imm_d       = imm_q;
    rs1_d       = rs1_q;
    rs2_d       = rs2_q;
    rd_d        = rd_q;
    funct3_d    = funct3_q;
    funct7b5_d  = funct7b5_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (load_s) begin
      valid_d    = id_valid_i;
      ctrl_d     = id_ctrl_i;
      pc_d       = id_pc_i;
      pc4_d      = id_pc4_i;
      rs1_data_d = id_rs1_data_i;
      rs2_data_d = id_rs2_data_i;
      imm_d      = id_imm_i;
      rs1_d      = id_rs1_i;
      rs2_d      = id_rs2_i;
      rd_d       = id_rd_i;
      funct3_d   = id_funct3_i;
      funct7b5_d = id_funct7b5_i;
    end else if (bubble_s) begin
      valid_d    = 1'b0;
      ctrl_d     = '0;
      pc_d       = '0;
      pc4_d      = '0;
      rs1_data_d = '0;
      rs2_data_d = '0;
      imm_d      = '0;
      rs1_d      = 5'd0;
      rs2_d      = 5'd0;
      rd_d       = 5'd0;
      funct3_d   = 3'd0;
      funct7b5_d = 1'b0;
      if (flush_i) begin
        if (flush_cnt_q != {CNT_W{1'b1}}) flush_cnt_d = flush_cnt_q + CNT_W'(1);
        else                              flush_cnt_d = flush_cnt_q;
      end else begin
        if (stall_cnt_q != {CNT_W{1'b1}}) stall_cnt_d = stall_cnt_q + CNT_W'(1);
        else                              stall_cnt_d = stall_cnt_q;
      end
    end else begin
      valid_d = valid_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q     <= 1'b0;
      ctrl_q      <= '0;
      pc_q        <= '0;
      pc4_q       <= '0;
      rs1_data_q  <= '0;
      rs2_data_q  <= '0;
      imm_q       <= '0;
      rs1_q       <= 5'd0;
      rs2_q       <= 5'd0;
      rd_q        <= 5'd0;
      funct3_q    <= 3'd0;
      funct7b5_q  <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      valid_q     <= valid_d;
      ctrl_q      <= ctrl_d;
      pc_q        <= pc_d;
      pc4_q       <= pc4_d;
      rs1_data_q  <= rs1_data_d;
      rs2_data_q  <= rs2_data_d;
      imm_q       <= imm_d;
      rs1_q       <= rs1_d;
      rs2_q       <= rs2_d;
      rd_q        <= rd_d;
      funct3_q    <= funct3_d;
      funct7b5_q  <= funct7b5_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign ex_valid_o    = valid_q;
  assign ex_ctrl_o     = ctrl_q;
  assign ex_pc_o       = pc_q;
  assign ex_pc4_o      = pc4_q;
  assign ex_rs1_data_o = rs1_data_q;
  assign ex_rs2_data_o = rs2_data_q;
  assign ex_imm_o      = imm_q;
  assign ex_rs1_o      = rs1_q;
  assign ex_rs2_o      = rs2_q;
  assign ex_rd_o       = rd_q;
  assign ex_funct3_o   = funct3_q;
  assign ex_funct7b5_o = funct7b5_q;
  assign stall_cnt_o   = stall_cnt_q;
  assign flush_cnt_o   = flush_cnt_q;

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Bench for id_ex_pipe_reg: directed vector table, hold/flush/reset sequences, random
// traffic against a behavioural model, and counter saturation.
module tb_id_ex_pipe_reg;

  typedef struct packed {
    logic        hold, flush, valid;
    logic [6:0]  op;
    logic [11:0] ctrl;
    logic [31:0] pc, rs1d, rs2d, imm;
    logic [4:0]  rs1, rs2, rd;
    logic [2:0]  f3;
    logic        f7;
  } in_t;

  typedef struct packed {
    logic        valid;
    logic [11:0] ctrl;
    logic [31:0] pc, pc4, rs1d, rs2d, imm;
    logic [4:0]  rs1, rs2, rd;
    logic [2:0]  f3;
    logic        f7;
    logic [15:0] scnt, fcnt;
  } mdl_t;

  typedef struct packed {
    in_t         i;
    logic        stall, valid;
    logic [11:0] ctrl;
    logic [4:0]  rd;
    logic [31:0] pc;
    logic [15:0] scnt, fcnt;
  } rec_t;

  localparam logic [6:0] R = 7'h33, LD = 7'h03, ST = 7'h23, BR = 7'h63, LUI = 7'h37;
  localparam logic [6:0] AUI = 7'h17, JAL = 7'h6F, IMM = 7'h13, JALR = 7'h67;
  localparam logic [11:0] C_ADD = 12'h804, C_LW = 12'hCA0, C_LUI = 12'hC00, C_SW = 12'h500;

  logic clk = 1'b0, rst_n = 1'b0;
  logic hold_i, flush_i, id_valid_i, id_funct7b5_i;
  logic [6:0] id_op_i;
  logic [11:0] id_ctrl_i;
  logic [31:0] id_pc_i, id_pc4_i, id_rs1_data_i, id_rs2_data_i, id_imm_i;
  logic [4:0] id_rs1_i, id_rs2_i, id_rd_i;
  logic [2:0] id_funct3_i;
  logic stall_o, ex_valid_o, ex_funct7b5_o;
  logic [11:0] ex_ctrl_o;
  logic [31:0] ex_pc_o, ex_pc4_o, ex_rs1_data_o, ex_rs2_data_o, ex_imm_o;
  logic [4:0] ex_rs1_o, ex_rs2_o, ex_rd_o;
  logic [2:0] ex_funct3_o;
  logic [15:0] stall_cnt_o, flush_cnt_o;

  int checks = 0, errors = 0;
  mdl_t mdl;
  rec_t tbl[17];

  always #5 clk = ~clk;

  id_ex_pipe_reg #(.XLEN(32), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .hold_i(hold_i), .flush_i(flush_i), .id_valid_i(id_valid_i),
    .id_op_i(id_op_i), .id_ctrl_i(id_ctrl_i), .id_pc_i(id_pc_i), .id_pc4_i(id_pc4_i),
    .id_rs1_data_i(id_rs1_data_i), .id_rs2_data_i(id_rs2_data_i), .id_imm_i(id_imm_i),
    .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i), .id_rd_i(id_rd_i), .id_funct3_i(id_funct3_i),
    .id_funct7b5_i(id_funct7b5_i), .stall_o(stall_o), .ex_valid_o(ex_valid_o),
    .ex_ctrl_o(ex_ctrl_o), .ex_pc_o(ex_pc_o), .ex_pc4_o(ex_pc4_o),
    .ex_rs1_data_o(ex_rs1_data_o), .ex_rs2_data_o(ex_rs2_data_o), .ex_imm_o(ex_imm_o),
    .ex_rs1_o(ex_rs1_o), .ex_rs2_o(ex_rs2_o), .ex_rd_o(ex_rd_o), .ex_funct3_o(ex_funct3_o),
    .ex_funct7b5_o(ex_funct7b5_o), .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
  );

  // Reference model: which sources an opcode reads, and what EX holds after one edge
  function automatic logic m_lu(mdl_t m, in_t x);
    logic r1, r2;
    r1 = !(x.op inside {LUI, AUI, JAL});
    r2 = x.op inside {R, ST, BR};
    return m.valid && m.ctrl[7] && m.rd != 5'd0 && x.valid &&
           ((r1 && x.rs1 == m.rd) || (r2 && x.rs2 == m.rd));
  endfunction

  function automatic logic m_stall(mdl_t m, in_t x);
    return x.hold || (m_lu(m, x) && !x.flush);
  endfunction

  function automatic mdl_t m_next(mdl_t m, in_t x, logic rn);
    mdl_t n;
    if (!rn) return '0;
    if (x.hold) return m;
    n = '0;
    n.scnt = m.scnt;
    n.fcnt = m.fcnt;
    if (x.flush) begin
      if (m.fcnt != 16'hFFFF) n.fcnt = m.fcnt + 16'd1;
    end else if (m_lu(m, x)) begin
      if (m.scnt != 16'hFFFF) n.scnt = m.scnt + 16'd1;
    end else begin
      n.valid = x.valid; n.ctrl = x.ctrl; n.pc = x.pc; n.pc4 = x.pc + 32'd4;
      n.rs1d = x.rs1d; n.rs2d = x.rs2d; n.imm = x.imm;
      n.rs1 = x.rs1; n.rs2 = x.rs2; n.rd = x.rd; n.f3 = x.f3; n.f7 = x.f7;
    end
    return n;
  endfunction

  function automatic in_t ins(logic [6:0] op, logic [11:0] c, logic [4:0] s1, logic [4:0] s2,
                              logic [4:0] d, logic [31:0] pc, logic v, logic fl, logic h);
    in_t x;
    x.hold = h; x.flush = fl; x.valid = v; x.op = op; x.ctrl = c; x.pc = pc;
    x.rs1d = pc ^ 32'h1111_0000; x.rs2d = pc ^ 32'h2222_0000; x.imm = pc + 32'h10;
    x.rs1 = s1; x.rs2 = s2; x.rd = d; x.f3 = pc[4:2]; x.f7 = pc[2];
    return x;
  endfunction

  function automatic rec_t rec(in_t x, logic st, logic v, logic [11:0] c, logic [4:0] d,
                               logic [31:0] pc, logic [15:0] sc, logic [15:0] fc);
    rec_t r;
    r.i = x; r.stall = st; r.valid = v; r.ctrl = c; r.rd = d; r.pc = pc; r.scnt = sc; r.fcnt = fc;
    return r;
  endfunction

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_all();
    cmp("ex_valid", 32'(ex_valid_o), 32'(mdl.valid));
    cmp("ex_ctrl", 32'(ex_ctrl_o), 32'(mdl.ctrl));
    cmp("ex_pc", ex_pc_o, mdl.pc);
    cmp("ex_pc4", ex_pc4_o, mdl.pc4);
    cmp("ex_rs1_data", ex_rs1_data_o, mdl.rs1d);
    cmp("ex_rs2_data", ex_rs2_data_o, mdl.rs2d);
    cmp("ex_imm", ex_imm_o, mdl.imm);
    cmp("ex_rs1", 32'(ex_rs1_o), 32'(mdl.rs1));
    cmp("ex_rs2", 32'(ex_rs2_o), 32'(mdl.rs2));
    cmp("ex_rd", 32'(ex_rd_o), 32'(mdl.rd));
    cmp("ex_funct3", 32'(ex_funct3_o), 32'(mdl.f3));
    cmp("ex_funct7b5", 32'(ex_funct7b5_o), 32'(mdl.f7));
    cmp("stall_cnt", 32'(stall_cnt_o), 32'(mdl.scnt));
    cmp("flush_cnt", 32'(flush_cnt_o), 32'(mdl.fcnt));
  endtask

  task automatic drive(input in_t x);
    hold_i = x.hold; flush_i = x.flush; id_valid_i = x.valid; id_op_i = x.op;
    id_ctrl_i = x.ctrl; id_pc_i = x.pc; id_pc4_i = x.pc + 32'd4; id_rs1_data_i = x.rs1d;
    id_rs2_data_i = x.rs2d; id_imm_i = x.imm; id_rs1_i = x.rs1; id_rs2_i = x.rs2;
    id_rd_i = x.rd; id_funct3_i = x.f3; id_funct7b5_i = x.f7;
  endtask

  // Called at posedge+1: drive, then check the combinational stall before the edge
  task automatic pre(input in_t x, input logic chk);
    drive(x);
    #1;
    if (chk) cmp("stall_o", 32'(stall_o), 32'(m_stall(mdl, x)));
  endtask

  task automatic post(input in_t x, input logic chk);
    @(posedge clk);
    mdl = m_next(mdl, x, rst_n);
    #1;
    if (chk) check_all();
  endtask

  initial begin
    in_t x;
    logic [6:0] opl[9];
    opl = '{R, LD, ST, BR, LUI, AUI, JAL, IMM, JALR};

    tbl[0]  = rec(ins(R,   C_ADD, 5'd1, 5'd2, 5'd3, 32'h100, 1'b1, 1'b0, 1'b0), 1'b0, 1'b1, C_ADD, 5'd3, 32'h100, 16'd0, 16'd0);
    tbl[1]  = rec(ins(LD,  C_LW,  5'd2, 5'd0, 5'd5, 32'h104, 1'b1, 1'b0, 1'b0), 1'b0, 1'b1, C_LW,  5'd5, 32'h104, 16'd0, 16'd0);
    tbl[2]  = rec(ins(R,   C_ADD, 5'd5, 5'd1, 5'd6, 32'h108, 1'b1, 1'b0, 1'b0), 1'b1, 1'b0, 12'h0, 5'd0, 32'h0,   16'd1, 16'd0);
    tbl[3]  = rec(ins(R,   C_ADD, 5'd5, 5'd1, 5'd6, 32'h108, 1'b1, 1'b0, 1'b0), 1'b0, 1'b1, C_ADD, 5'd6, 32'h108, 16'd1, 16'd0);
    tbl[4]  = rec(ins(LD,  C_LW,  5'd1, 5'd0, 5'd0, 32'h10C, 1'b1, 1'b0, 1'b0), 1'b0, 1'b1, C_LW,  5'd0, 32'h10C, 16'd1, 16'd0);
    tbl[5]  = rec(ins(R,   C_ADD, 5'd0, 5'd0, 5'd7, 32'h110, 1'b1, 1'b0, 1'b0), 1'b0, 1'b1, C_ADD, 5'd7, 32'h110, 16'd1, 16'd0);
    tbl[6]  = rec(ins(LD,  C_LW,  5'd1, 5'd0, 5'd5, 32'h114, 1'b1, 1'b0, 1'b0), 1'b0, 1'b1, C_LW,  5'd5, 32'h114, 16'd1, 16'd0);
    tbl[7]  = rec(ins(LUI, C_LUI, 5'd5, 5'd5, 5'd5, 32'h118, 1'b1, 1'b0, 1'b0), 1'b0, 1'b1, C_LUI, 5'd5, 32'h118, 16'd1, 16'd0);
    tbl[8]  = rec(ins(LD,  C_LW,  5'd1, 5'd0, 5'd5, 32'h11C, 1'b1, 1'b0, 1'b0), 1'b0, 1'b1, C_LW,  5'd5, 32'h11C, 16'd1, 16'd0);
    tbl[9]  = rec(ins(ST,  C_SW,  5'd1, 5'd5, 5'd0, 32'h120, 1'b1, 1'b0, 1'b0), 1'b1, 1'b0, 12'h0, 5'd0, 32'h0,   16'd2, 16'd0);
    tbl[10] = rec(ins(ST,  C_SW,  5'd1, 5'd5, 5'd0, 32'h120, 1'b1, 1'b0, 1'b0), 1'b0, 1'b1, C_SW,  5'd0, 32'h120, 16'd2, 16'd0);
    tbl[11] = rec(ins(LD,  C_LW,  5'd1, 5'd0, 5'd5, 32'h124, 1'b1, 1'b0, 1'b0), 1'b0, 1'b1, C_LW,  5'd5, 32'h124, 16'd2, 16'd0);
    tbl[12] = rec(ins(R,   C_ADD, 5'd5, 5'd1, 5'd6, 32'h128, 1'b1, 1'b1, 1'b0), 1'b0, 1'b0, 12'h0, 5'd0, 32'h0,   16'd2, 16'd1);
    tbl[13] = rec(ins(R,   C_ADD, 5'd1, 5'd2, 5'd8, 32'h12C, 1'b1, 1'b0, 1'b0), 1'b0, 1'b1, C_ADD, 5'd8, 32'h12C, 16'd2, 16'd1);
    tbl[14] = rec(ins(R,   C_ADD, 5'd1, 5'd2, 5'd9, 32'h130, 1'b0, 1'b0, 1'b0), 1'b0, 1'b0, C_ADD, 5'd9, 32'h130, 16'd2, 16'd1);
    tbl[15] = rec(ins(LD,  C_LW,  5'd1, 5'd0, 5'd5, 32'h134, 1'b1, 1'b0, 1'b0), 1'b0, 1'b1, C_LW,  5'd5, 32'h134, 16'd2, 16'd1);
    tbl[16] = rec(ins(R,   C_ADD, 5'd5, 5'd1, 5'd6, 32'h138, 1'b0, 1'b0, 1'b0), 1'b0, 1'b0, C_ADD, 5'd6, 32'h138, 16'd2, 16'd1);

    // Reset held two cycles with a valid instruction offered
    x = ins(R, C_ADD, 5'd1, 5'd2, 5'd3, 32'h80, 1'b1, 1'b0, 1'b0);
    drive(x);
    mdl = '0;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk);
      #1;
      cmp("rst_valid", 32'(ex_valid_o), 32'd0);
      cmp("rst_ctrl", 32'(ex_ctrl_o), 32'd0);
      cmp("rst_cnt", 32'({stall_cnt_o, flush_cnt_o}), 32'd0);
      check_all();
    end
    rst_n = 1'b1;

    for (int k = 0; k < 17; k++) begin
      pre(tbl[k].i, 1'b1);
      cmp($sformatf("vec%0d_stall", k), 32'(stall_o), 32'(tbl[k].stall));
      post(tbl[k].i, 1'b1);
      cmp($sformatf("vec%0d_valid", k), 32'(ex_valid_o), 32'(tbl[k].valid));
      cmp($sformatf("vec%0d_ctrl", k), 32'(ex_ctrl_o), 32'(tbl[k].ctrl));
      cmp($sformatf("vec%0d_rd", k), 32'(ex_rd_o), 32'(tbl[k].rd));
      cmp($sformatf("vec%0d_pc", k), ex_pc_o, tbl[k].pc);
      cmp($sformatf("vec%0d_cnt", k), {stall_cnt_o, flush_cnt_o}, {tbl[k].scnt, tbl[k].fcnt});
    end

    // Hold with flush asserted: EX frozen, flush counted only once hold drops
    x = ins(R, C_ADD, 5'd1, 5'd2, 5'd3, 32'h200, 1'b1, 1'b0, 1'b0);
    pre(x, 1'b1); post(x, 1'b1);
    for (int k = 0; k < 3; k++) begin
      x = ins(R, C_ADD, 5'd4, 5'd4, 5'd9, 32'h300 + 32'(k * 4), 1'b1, 1'b1, 1'b1);
      pre(x, 1'b1);
      cmp("hold_stall", 32'(stall_o), 32'd1);
      post(x, 1'b1);
      cmp("hold_pc", ex_pc_o, 32'h200);
      cmp("hold_fcnt", 32'(flush_cnt_o), 32'd1);
    end
    x.hold = 1'b0;
    pre(x, 1'b1); post(x, 1'b1);
    cmp("unhold_valid", 32'(ex_valid_o), 32'd0);
    cmp("unhold_fcnt", 32'(flush_cnt_o), 32'd2);

    // Reset asserted while holding still clears everything
    x = ins(R, C_ADD, 5'd1, 5'd2, 5'd3, 32'h400, 1'b1, 1'b0, 1'b1);
    rst_n = 1'b0;
    pre(x, 1'b0); post(x, 1'b1);
    cmp("rst_hold_cnt", 32'({stall_cnt_o, flush_cnt_o}), 32'd0);
    rst_n = 1'b1;

    // Random traffic with narrow register indices so hazards are frequent
    for (int k = 0; k < 3000; k++) begin
      x.hold  = ($urandom_range(0, 7) == 0);
      x.flush = ($urandom_range(0, 7) == 0);
      x.valid = ($urandom_range(0, 7) != 0);
      x.op    = opl[$urandom_range(0, 8)];
      x.ctrl  = 12'($urandom) & 12'hFFE;
      x.pc    = $urandom; x.rs1d = $urandom; x.rs2d = $urandom; x.imm = $urandom;
      x.rs1   = 5'($urandom_range(0, 3));
      x.rs2   = 5'($urandom_range(0, 3));
      x.rd    = 5'($urandom_range(0, 3));
      x.f3    = 3'($urandom); x.f7 = 1'($urandom);
      rst_n   = ($urandom_range(0, 299) != 0);
      pre(x, 1'b1); post(x, 1'b1);
    end
    rst_n = 1'b1;

    // Drive a continuous flush until the flush counter pins at all-ones
    x = ins(R, C_ADD, 5'd1, 5'd2, 5'd3, 32'h500, 1'b1, 1'b1, 1'b0);
    rst_n = 1'b0;
    pre(x, 1'b0); post(x, 1'b1);
    rst_n = 1'b1;
    drive(x);
    for (int k = 0; k < 65534; k++) post(x, 1'b0);
    check_all();
    cmp("fcnt_near_max", 32'(flush_cnt_o), 32'hFFFE);
    for (int k = 0; k < 3; k++) begin
      post(x, 1'b1);
      cmp("fcnt_sat", 32'(flush_cnt_o), 32'hFFFF);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
